frame_serializer: RTL and testbench
===================================

// Module: frame_serializer
// PURPOSE
//  Transmit side of the single-wire port-addressed frame link: accepts a parallel
//  request (target port, payload length, payload bits) and shifts it out as
//  start bit, 2-bit port, 4-bit length and N payload bits.
//  Sits upstream of the frame receiver that demuxes payload onto P0..P3.
//  Line idles high. All advancement is qualified by clkEn.
// PARAMETERS
//  PORT_W  2   width of port-address field (MSB first on line)
//  LEN_W   4   width of length field (MSB first); max payload = 2**LEN_W-1
// PORTS
//  clk          in   1        system clock, rising edge
//  rstN         in   1        asynchronous active-low reset
//  clkEn        in   1        clock enable; state/outputs advance only when 1
//  start        in   1        request; sampled only in IDLE with clkEn=1
//  portIn       in   PORT_W   target port, latched on accept
//  lenIn        in   LEN_W    payload bit count N (0..15), latched on accept
//  dataIn       in   2**LEN_W-1  payload, latched on accept; dataIn[0] sent first
//  serOut       out  1        serial line
//  serOutValid  out  1        high only while a payload bit is on serOut
//  busy         out  1        high from START through DONE
//  done         out  1        high in DONE state (one enabled cycle)
// BEHAVIOUR
//  Reset (async, rstN=0): state=IDLE, serOut=1, serOutValid=0, busy=0, done=0,
//   all latches cleared; a frame in progress is aborted, line goes high at once.
//  FSM (transitions only on clk edge with clkEn=1):
//   IDLE : serOut=1; start=1 -> latch inputs, go START
//   START: serOut=0 for 1 bit -> PORT
//   PORT : PORT_W bits, portIn MSB first -> LEN
//   LEN  : LEN_W bits, lenIn MSB first -> DATA if N>0, else DONE
//   DATA : N bits, dataIn[0]..dataIn[N-1]; serOutValid=1 -> DONE
//   DONE : serOut=1, done=1, busy=1, 1 bit -> IDLE
//  Frame length 1+PORT_W+LEN_W+N bits; done on the enabled cycle after last bit.
//  clkEn=0: state, counters and all outputs hold (done may stay high >1 clk).
//  start while busy: ignored, not queued. Inputs may change freely after accept.
//  Min line-high gap between frames = 2 bits (DONE + IDLE accept cycle).
//  Outputs registered; serOut never glitches within a bit.
// CONFIGURATION
//  FRAME_PARITY_EN defined: one even-parity bit (XOR of payload bits sent) is
//   inserted after DATA (or after LEN if N=0, value 0), state PARITY,
//   serOutValid=0 during it; frame = 2+PORT_W+LEN_W+N bits.
//  Undefined (default, matches current receiver): no parity bit, no PARITY state.
// STRUCTURE
//  frame_pkg: state encoding, PORT_W/LEN_W defaults, START_BIT=0, IDLE_BIT=1.
//  Sub-module frame_bit_counter: loadable LEN_W-bit down-counter with clkEn and
//   zero flag, reused per field (PORT, LEN, DATA). Shift register in top level.
// TESTING
//  1 rstN=0 mid-DATA -> serOut=1, busy=0, done=0 immediately, IDLE after release.
//  2 port=3,len=8,data=0x0B3 -> serOut 0,1,1,1,0,0,0,1,1,0,0,1,1,0,1 then 1;
//    serOutValid high exactly 8 enabled cycles; done 1 cycle after.
//  3 port=1,len=0 -> serOut 0,0,1,0,0,0,0, done next cycle, serOutValid never 1.
//  4 len=15, clkEn low 3 clks mid-DATA -> line/state frozen; bit sequence intact.
//  5 start held high through a frame -> second frame begins only after DONE,IDLE.
//  6 FRAME_PARITY_EN, len=3,data=3'b011 -> parity bit 0 after payload, then DONE.

Source files
------------

// File: rtl/frame_pkg.sv
// -----------------------------------------------------------------------------
// frame_pkg
//   Shared definitions for the single-wire frame serializer: field widths,
//   line levels and the FSM state encoding.
//   Optional feature macro: FRAME_PARITY_EN adds the PARITY state.
// -----------------------------------------------------------------------------
package frame_pkg;

   localparam int PORT_W = 2;                  // port-address field width
   localparam int LEN_W  = 4;                  // length field width
   localparam int DATA_W = (2 ** LEN_W) - 1;   // widest possible payload
   localparam int HDR_W  = PORT_W + LEN_W;     // port + length, sent back to back

   localparam logic START_BIT = 1'b0;
   localparam logic IDLE_BIT  = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_PORT,
      S_LEN,
      S_DATA,
      S_DONE
`ifdef FRAME_PARITY_EN
      , S_PARITY
`endif
   } state_e;

endpackage

// File: rtl/frame_serializer_if.sv
// -----------------------------------------------------------------------------
// frame_serializer_if
//   Request/line bundle for frame_serializer.
//   master : request source (drives start/portIn/lenIn/dataIn, observes line)
//   slave  : the serializer itself
// -----------------------------------------------------------------------------
interface frame_serializer_if;
   import frame_pkg::*;

   logic              start;
   logic [PORT_W-1:0] portIn;
   logic [LEN_W-1:0]  lenIn;
   logic [DATA_W-1:0] dataIn;
   logic              serOut;
   logic              serOutValid;
   logic              busy;
   logic              done;

   modport master (
      output start, portIn, lenIn, dataIn,
      input  serOut, serOutValid, busy, done
   );

   modport slave (
      input  start, portIn, lenIn, dataIn,
      output serOut, serOutValid, busy, done
   );

endinterface

// File: rtl/frame_bit_counter.sv
// -----------------------------------------------------------------------------
// frame_bit_counter
//   Loadable LEN_W-bit down-counter shared by the PORT, LEN and DATA fields.
//   Holds the number of bits still to follow the one currently on the line.
//   Ports: clk, rstN (async, active low), clkEn (advance enable),
//          load/load_val (load wins over dec), dec (count down, saturates at 0),
//          count (current value), zero (count == 0).
// -----------------------------------------------------------------------------
module frame_bit_counter
   import frame_pkg::*;
(
   input  logic             clk,
   input  logic             rstN,
   input  logic             clkEn,
   input  logic             load,
   input  logic [LEN_W-1:0] load_val,
   input  logic             dec,
   output logic [LEN_W-1:0] count,
   output logic             zero
);

   logic [LEN_W-1:0] count_q, count_d;

   always_comb begin
      // NOTE: every combinationally assigned signal gets a default first so no path leaves it unassigned (no latch).
      count_d = count_q;
      if (clkEn) begin
         if (load) begin
            count_d = load_val;
         end else if (dec && (count_q != '0)) begin
            count_d = count_q - LEN_W'(1);
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) count_q <= '0;
      else       count_q <= count_d;
   end

   assign count = count_q;
   assign zero  = (count_q == '0);

endmodule

// File: rtl/frame_serializer.sv
// -----------------------------------------------------------------------------
// frame_serializer
//   Transmit side of the single-wire port-addressed frame link. Accepts a
//   request (port, length N, payload) and shifts out: start bit (0), port MSB
//   first, length MSB first, then N payload bits LSB first, followed by one
//   high DONE bit. The line idles high; everything advances only on clkEn.
//   Ports: clk, rstN (async, active low), clkEn (advance enable),
//          bus (frame_serializer_if.slave: start/portIn/lenIn/dataIn in,
//               serOut/serOutValid/busy/done out, all outputs registered).
//   Optional feature macro: FRAME_PARITY_EN inserts one even-parity bit
//   (XOR of the payload bits sent, 0 for an empty payload) before DONE.
// -----------------------------------------------------------------------------
module frame_serializer
   import frame_pkg::*;
(
   input  logic clk,
   input  logic rstN,
   input  logic clkEn,
   frame_serializer_if.slave bus
);

   state_e            state_q, state_d;
   logic [HDR_W-1:0]  hdr_q, hdr_d;     // {port, len}, shifted left as sent
   logic [LEN_W-1:0]  len_q, len_d;     // unshifted copy for the DATA count
   logic [DATA_W-1:0] data_q, data_d;   // payload, shifted right as sent
   logic              par_q, par_d;
   logic              ser_out_q, ser_out_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              cnt_load, cnt_dec, cnt_zero;
   logic [LEN_W-1:0]  cnt_val, cnt_count;
   logic              payload_end;

   frame_bit_counter u_cnt (
      .clk      (clk),
      .rstN     (rstN),
      .clkEn    (clkEn),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .count    (cnt_count),
      .zero     (cnt_zero)
   );

   // Outputs are registered, so each branch computes the bit that will be on
   // the line during the state being entered, not the current one.
   always_comb begin
      state_d     = state_q;
      hdr_d       = hdr_q;
      len_d       = len_q;
      data_d      = data_q;
      par_d       = par_q;
      ser_out_d   = ser_out_q;
      valid_d     = valid_q;
      cnt_load    = 1'b0;
      cnt_val     = '0;
      cnt_dec     = 1'b0;
      payload_end = 1'b0;

      if (clkEn) begin
         ser_out_d = IDLE_BIT;
         valid_d   = 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  state_d   = S_START;
                  hdr_d     = {bus.portIn, bus.lenIn};
                  len_d     = bus.lenIn;
                  data_d    = bus.dataIn;
                  par_d     = 1'b0;
                  ser_out_d = START_BIT;
               end
            end
            S_START: begin
               state_d   = S_PORT;
               cnt_load  = 1'b1;
               cnt_val   = LEN_W'(PORT_W - 1);
               ser_out_d = hdr_q[HDR_W-1];
               hdr_d     = hdr_q << 1;
            end
            S_PORT: begin
               // Port and length are contiguous in hdr_q, so the next bit is
               // always its MSB whether or not the field changes here.
               ser_out_d = hdr_q[HDR_W-1];
               hdr_d     = hdr_q << 1;
               if (cnt_zero) begin
                  state_d  = S_LEN;
                  cnt_load = 1'b1;
                  cnt_val  = LEN_W'(LEN_W - 1);
               end else begin
                  cnt_dec = 1'b1;
               end
            end
            S_LEN: begin
               if (!cnt_zero) begin
                  cnt_dec   = 1'b1;
                  ser_out_d = hdr_q[HDR_W-1];
                  hdr_d     = hdr_q << 1;
               end else if (len_q != '0) begin
                  state_d   = S_DATA;
                  cnt_load  = 1'b1;
                  cnt_val   = len_q - LEN_W'(1);
                  ser_out_d = data_q[0];
                  valid_d   = 1'b1;
                  data_d    = data_q >> 1;
                  par_d     = par_q ^ data_q[0];
               end else begin
                  payload_end = 1'b1;
               end
            end
            S_DATA: begin
               if (!cnt_zero) begin
                  cnt_dec   = 1'b1;
                  ser_out_d = data_q[0];
                  valid_d   = 1'b1;
                  data_d    = data_q >> 1;
                  par_d     = par_q ^ data_q[0];
               end else begin
                  payload_end = 1'b1;
               end
            end
`ifdef FRAME_PARITY_EN
            S_PARITY: state_d = S_DONE;
`endif
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
         endcase

         if (payload_end) begin
`ifdef FRAME_PARITY_EN
            state_d   = S_PARITY;
            ser_out_d = par_q;
`else
            state_d   = S_DONE;
`endif
         end
      end
   end

   // Decoded from the next state so they hold along with it when clkEn=0.
   assign busy_d = (state_d != S_IDLE);
   assign done_d = (state_d == S_DONE);

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q   <= S_IDLE;
         hdr_q     <= '0;
         len_q     <= '0;
         data_q    <= '0;
         par_q     <= 1'b0;
         ser_out_q <= IDLE_BIT;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         hdr_q     <= hdr_d;
         len_q     <= len_d;
         data_q    <= data_d;
         par_q     <= par_d;
         ser_out_q <= ser_out_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.serOut      = ser_out_q;
   assign bus.serOutValid = valid_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;

endmodule

// File: tb/tb_frame_serializer.sv
// -----------------------------------------------------------------------------
// tb_frame_serializer
//   Directed, table-driven bench for frame_serializer. Each table entry holds a
//   request and its hand-computed line bit stream (first bit leftmost) plus the
//   expected parity bit for builds with FRAME_PARITY_EN. Line state is checked
//   as the packed tuple {serOut, serOutValid, busy, done} once per bit.
// -----------------------------------------------------------------------------
module tb_frame_serializer;
   import frame_pkg::*;

   localparam int HDR_BITS = 1 + PORT_W + LEN_W;

   logic clk = 1'b0;
   logic rstN;
   logic clkEn;

   frame_serializer_if bus ();

   frame_serializer dut (
      .clk   (clk),
      .rstN  (rstN),
      .clkEn (clkEn),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [PORT_W-1:0] port;
      logic [LEN_W-1:0]  len;
      logic [DATA_W-1:0] data;
      int                nbits;   // header + payload bits
      logic [31:0]       bits;    // first bit on the line at [nbits-1]
      logic              par;     // even parity of payload
      int                stall_at;
   } vec_t;

   vec_t vecs[6];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] line_now();
      return {28'd0, bus.serOut, bus.serOutValid, bus.busy, bus.done};
   endfunction

   function automatic logic [31:0] line_exp(input logic s, input logic v,
                                            input logic b, input logic d);
      return {28'd0, s, v, b, d};
   endfunction

   // Sends one frame and checks every bit. With hold_start the request stays
   // high and the bench stops after the DONE->IDLE edge without checking IDLE.
   task automatic run_frame(input int id, input vec_t v, input bit hold_start);
      logic [31:0] exp;
      bus.portIn = v.port;
      bus.lenIn  = v.len;
      bus.dataIn = v.data;
      bus.start  = 1'b1;
      step();
      if (!hold_start) bus.start = 1'b0;
      // Inputs are latched on accept; scramble them to prove it.
      bus.portIn = ~v.port;
      bus.lenIn  = ~v.len;
      bus.dataIn = ~v.data;
      for (int i = 0; i < v.nbits; i++) begin
         exp = line_exp(v.bits[v.nbits-1-i], (i >= HDR_BITS), 1'b1, 1'b0);
         check($sformatf("f%0d bit%0d", id, i), line_now(), exp);
         if (i == v.stall_at) begin
            clkEn = 1'b0;
            for (int s = 0; s < 3; s++) begin
               step();
               check($sformatf("f%0d stall%0d", id, s), line_now(), exp);
            end
            clkEn = 1'b1;
         end
         step();
      end
`ifdef FRAME_PARITY_EN
      check($sformatf("f%0d parity", id), line_now(), line_exp(v.par, 1'b0, 1'b1, 1'b0));
      step();
`endif
      check($sformatf("f%0d done", id), line_now(), line_exp(1'b1, 1'b0, 1'b1, 1'b1));
      step();
      if (!hold_start)
         check($sformatf("f%0d idle", id), line_now(), line_exp(1'b1, 1'b0, 1'b0, 1'b0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rstN       = 1'b0;
      clkEn      = 1'b1;
      bus.start  = 1'b0;
      bus.portIn = '0;
      bus.lenIn  = '0;
      bus.dataIn = '0;

      vecs[0] = '{port: 2'd3, len: 4'd8,  data: 15'h00B3, nbits: 15,
                  bits: 32'(15'b011100011001101), par: 1'b1, stall_at: -1};
      vecs[1] = '{port: 2'd1, len: 4'd0,  data: 15'h7FFF, nbits: 7,
                  bits: 32'(7'b0010000), par: 1'b0, stall_at: -1};
      vecs[2] = '{port: 2'd2, len: 4'd1,  data: 15'h0001, nbits: 8,
                  bits: 32'(8'b01000011), par: 1'b1, stall_at: -1};
      vecs[3] = '{port: 2'd0, len: 4'd15, data: 15'h4D2B, nbits: 22,
                  bits: 32'(22'b0001111_110101001011001), par: 1'b0, stall_at: 12};
      vecs[4] = '{port: 2'd2, len: 4'd5,  data: 15'h0016, nbits: 12,
                  bits: 32'(12'b010010101101), par: 1'b1, stall_at: -1};
      vecs[5] = '{port: 2'd1, len: 4'd3,  data: 15'h0003, nbits: 10,
                  bits: 32'(10'b0010011110), par: 1'b0, stall_at: -1};

      #12;
      check("reset state", line_now(), line_exp(1'b1, 1'b0, 1'b0, 1'b0));
      rstN = 1'b1;
      step();
      check("idle after reset", line_now(), line_exp(1'b1, 1'b0, 1'b0, 1'b0));

      for (int k = 0; k < 6; k++) run_frame(k, vecs[k], 1'b0);

      // Reset in the middle of the payload: line high at once, no edge needed.
      bus.portIn = vecs[3].port;
      bus.lenIn  = vecs[3].len;
      bus.dataIn = vecs[3].data;
      bus.start  = 1'b1;
      step();
      bus.start = 1'b0;
      repeat (9) step();
      check("mid-data valid", 32'(bus.serOutValid), 32'd1);
      #2 rstN = 1'b0;
      #1 check("async abort", line_now(), line_exp(1'b1, 1'b0, 1'b0, 1'b0));
      step();
      rstN = 1'b1;
      step();
      check("idle after abort", line_now(), line_exp(1'b1, 1'b0, 1'b0, 1'b0));

      // Start held high: DONE and IDLE must both appear before the next START.
      run_frame(10, vecs[1], 1'b1);
      check("held start gap", line_now(), line_exp(1'b1, 1'b0, 1'b0, 1'b0));
      run_frame(11, vecs[5], 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
